// File: rtl/mult_control_unit_pkg.sv
// Shared definitions for the shift-add multiplier controller: state encoding and default sizes.
package mult_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mult_control_unit_if.sv
// Requester handshake plus Product-datapath control bundle for the multiplier controller.
// Handshake: start is sampled only while idle; busy covers LOAD..DONE; rdy is a one-cycle done pulse.
interface mult_control_unit_if #(
    parameter int CNT_W = mult_pkg::DEF_CNT_W
) ();
    import mult_pkg::*;

    logic             start;
    logic             abort;
    logic             lsb;
    logic             busy;
    logic             load_ctrl;
    logic             w_ctrl_Product;
    logic             adding_ctrl;
    logic             rdy;
    logic [CNT_W-1:0] iter;
    state_t           state;

    modport slave (
        input  start, abort, lsb,
        output busy, load_ctrl, w_ctrl_Product, adding_ctrl, rdy, iter, state
    );

    modport master (
        output start, abort, lsb,
        input  busy, load_ctrl, w_ctrl_Product, adding_ctrl, rdy, iter, state
    );

endinterface

// File: rtl/mult_control_unit_iter_counter.sv
// Iteration counter for the multiplier sequencer; clear has priority over enable.
module mult_iter_counter #(
    parameter int WIDTH = mult_pkg::DEF_WIDTH,
    parameter int CNT_W = mult_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [CNT_W-1:0] count_o,
    output logic             terminal_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign terminal_o = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_control_unit.sv
// Sequencer for the unsigned shift-add multiplier: one LOAD cycle, WIDTH add/shift cycles, one DONE cycle.
module mult_control_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic               clk,
    input logic               rst,
    mult_control_unit_if.slave ctrl
);

    state_t           state_q;
    state_t           state_d;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             cnt_terminal;
    logic [CNT_W-1:0] cnt_value;
    logic             busy;
    logic             load_ctrl;
    logic             w_ctrl;
    logic             adding;
    logic             rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ctrl.start) state_d = S_LOAD;
            S_LOAD:  state_d = S_RUN;
            S_RUN:   if (cnt_terminal) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort also wins over a simultaneous start while idle.
        if (ctrl.abort) state_d = S_IDLE;
    end

    always_comb begin
        busy      = 1'b0;
        load_ctrl = 1'b0;
        w_ctrl    = 1'b0;
        adding    = 1'b0;
        rdy       = 1'b0;
        case (state_q)
            S_LOAD: begin
                busy      = 1'b1;
                load_ctrl = 1'b1;
            end
            S_RUN: begin
                busy   = 1'b1;
                w_ctrl = 1'b1;
                adding = ctrl.lsb;
            end
            S_DONE: begin
                busy = 1'b1;
                rdy  = 1'b1;
            end
            default: ;
        endcase
    end

    // Clearing on the transition into IDLE keeps iter at 0 for every idle cycle; DONE holds WIDTH.
    assign cnt_clear  = (state_d == S_IDLE) || (state_d == S_LOAD);
    assign cnt_enable = (state_q == S_RUN);

    mult_iter_counter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_iter_counter (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (cnt_clear),
        .enable_i  (cnt_enable),
        .count_o   (cnt_value),
        .terminal_o(cnt_terminal)
    );

    assign ctrl.busy           = busy;
    assign ctrl.load_ctrl      = load_ctrl;
    assign ctrl.w_ctrl_Product = w_ctrl;
    assign ctrl.adding_ctrl    = adding;
    assign ctrl.rdy            = rdy;
    assign ctrl.iter           = cnt_value;
    assign ctrl.state          = state_q;

endmodule

// File: tb/tb_mult_control_unit.sv
// Bench for mult_control_unit: drives a behavioural Product/Multiplicand datapath and checks controls and products.
module tb_mult_control_unit;
    import mult_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_control_unit_if #(.CNT_W(CNT_W)) bus ();

    mult_control_unit #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctrl(bus)
    );

    // Behavioural datapath: Product shifts right each write, adding the multiplicand into the high half.
    logic [31:0] mplier;
    logic [31:0] mcand;
    logic [31:0] mcand_q = '0;
    logic [63:0] prod_q  = '0;
    logic [32:0] sum;

    assign sum     = {1'b0, prod_q[63:32]} + (bus.adding_ctrl ? {1'b0, mcand_q} : 33'd0);
    assign bus.lsb = prod_q[0];

    always @(posedge clk) begin
        if (bus.load_ctrl) begin
            prod_q  <= {32'd0, mplier};
            mcand_q <= mcand;
        end else if (bus.w_ctrl_Product) begin
            prod_q <= 64'({sum, prod_q[31:0]} >> 1);
        end
    end

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ctl_bits();
        return 64'({bus.busy, bus.load_ctrl, bus.w_ctrl_Product, bus.adding_ctrl, bus.rdy});
    endfunction

    task automatic check_idle(input string name);
        check({name, "_ctl"}, ctl_bits(), 64'd0);
        check({name, "_iter"}, 64'(bus.iter), 64'd0);
        check({name, "_state"}, 64'(bus.state), 64'(S_IDLE));
    endtask

    // Called at a falling edge; returns at a falling edge one idle cycle after rdy.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
        mplier = a;
        mcand  = b;
        exp_q.push_back(p);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("load_ctl", ctl_bits(), 64'b11000);
        check("load_iter", 64'(bus.iter), 64'd0);
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            check("run_ctl", 64'({bus.busy, bus.load_ctrl, bus.w_ctrl_Product, bus.rdy}), 64'b1010);
            check("run_add", 64'(bus.adding_ctrl), 64'(a[k]));
            check("run_iter", 64'(bus.iter), 64'(k));
        end
        @(negedge clk);
        check("done_ctl", ctl_bits(), 64'b10001);
        check("done_product", prod_q, exp_q.pop_front());
        @(negedge clk);
        check_idle("after_done");
    endtask

    vec_t vecs[7];
    int   rdy_cnt;
    int   first_rdy;
    int   last_rdy;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        vecs[0] = '{32'h1000_0000, 32'h0000_0003, 64'h0000_0000_3000_0000};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h0000_0000, 32'h0001_2345, 64'h0000_0000_0000_0000};
        vecs[3] = '{32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0001};
        vecs[4] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
        vecs[5] = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001};
        vecs[6] = '{32'h0000_0002, 32'hFFFF_FFFF, 64'h0000_0001_FFFF_FFFE};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        mplier    = '0;
        mcand     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle("idle_hold");
        end

        for (int i = 0; i < 7; i++) begin
            do_mult(vecs[i].a, vecs[i].b, vecs[i].p);
        end

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_mult(ra, rb, 64'(ra) * 64'(rb));
        end

        // start held high: two full runs within 80 cycles, rdy 35 cycles apart
        mplier    = 32'h0000_0005;
        mcand     = 32'h0000_0007;
        rdy_cnt   = 0;
        first_rdy = -1;
        last_rdy  = -1;
        bus.start = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (bus.rdy === 1'b1) begin
                rdy_cnt++;
                if (first_rdy < 0) first_rdy = i;
                last_rdy = i;
                check("held_product", prod_q, 64'd35);
            end
        end
        check("held_rdy_count", 64'(rdy_cnt), 64'd2);
        check("held_first_rdy", 64'(first_rdy), 64'd34);
        check("held_rdy_spacing", 64'(last_rdy - first_rdy), 64'd35);
        check("held_third_busy", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_idle("held_abort");

        // abort at RUN iter 10
        mplier    = 32'hFFFF_FFFF;
        mcand     = 32'h0000_0001;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        check("abort_pre_iter", 64'(bus.iter), 64'd10);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_idle("abort_next");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle("abort_quiet");
        end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_idle("abort_with_start");
        do_mult(32'h0000_0F0F, 32'h0000_1000, 64'h0000_0000_00F0_F000);

        // asynchronous reset at RUN iter 20
        mplier    = 32'h1234_5678;
        mcand     = 32'h0000_0010;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (21) @(negedge clk);
        check("rst_pre_iter", 64'(bus.iter), 64'd20);
        #2 rst = 1'b1;
        #1 check_idle("rst_async");
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_release");
        do_mult(32'h1000_0000, 32'h0000_0003, 64'h0000_0000_3000_0000);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
